// File: rtl/fetch_ctrl_pkg.sv
// Shared CPU package: fetch FSM state encoding, datapath widths and an
// address-alignment helper used by the fetch controller.
package fetch_ctrl_pkg;

  localparam int INST_W = 32;
  localparam int ADDR_W = 32;
  localparam int CNT_W  = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    ISSUE  = 2'd2,
    HALTED = 2'd3
  } fetch_state_e;

  function automatic logic [ADDR_W-1:0] align_word(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_ctrl_pc_reg.sv
// Architectural fetch PC: 32-bit register with write enable and
// asynchronous clear to RESET_PC.
module pc_reg
  import fetch_ctrl_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              we,
  input  logic [ADDR_W-1:0] d,
  output logic [ADDR_W-1:0] q
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge clr) begin
    if (clr)     q <= RESET_PC;
    else if (we) q <= d;
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: single-outstanding fetch, one-entry issue
// buffer toward decode, redirect with response kill, halt and issue counter.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              clr,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt,
  output logic [ADDR_W-1:0] pc,
  output logic              misalign_err,
  output logic [CNT_W-1:0]  issue_cnt
);

  fetch_state_e      state;
  logic              kill;
  logic              pc_we;
  logic [ADDR_W-1:0] pc_d;

  pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
    .clk (clk),
    .clr (clr),
    .we  (pc_we),
    .d   (pc_d),
    .q   (pc)
  );

  assign imem_addr = pc;

  // NOTE: every output of this block gets a default first so no path
  // through the case leaves a value unassigned (no latch).
  always_comb begin
    pc_we = 1'b0;
    pc_d  = pc + 32'd4;
    case (state)
      IDLE, FETCH: begin
        if (redirect) begin
          pc_we = 1'b1;
          pc_d  = align_word(redirect_pc);
        end
      end
      ISSUE: begin
        if (redirect) begin
          pc_we = 1'b1;
          pc_d  = align_word(redirect_pc);
        end else if (inst_ready) begin
          pc_we = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state        <= IDLE;
      imem_req     <= 1'b0;
      inst_valid   <= 1'b0;
      inst         <= '0;
      inst_pc      <= '0;
      kill         <= 1'b0;
      misalign_err <= 1'b0;
      issue_cnt    <= '0;
    end else begin
      if (redirect && state != HALTED && redirect_pc[1:0] != 2'b00)
        misalign_err <= 1'b1;

      case (state)
        IDLE: begin
          state    <= FETCH;
          imem_req <= 1'b1;
        end
        FETCH: begin
          // A redirect before the ack poisons the in-flight response; a
          // redirect coinciding with the ack simply drops that data.
          if (imem_ack) begin
            kill <= 1'b0;
            if (!redirect && !kill) begin
              inst       <= imem_rdata;
              inst_pc    <= pc;
              inst_valid <= 1'b1;
              imem_req   <= 1'b0;
              state      <= ISSUE;
            end
          end else if (redirect) begin
            kill <= 1'b1;
          end
        end
        ISSUE: begin
          if (redirect) begin
            inst_valid <= 1'b0;
            imem_req   <= 1'b1;
            state      <= FETCH;
          end else if (inst_ready) begin
            inst_valid <= 1'b0;
            if (issue_cnt != {CNT_W{1'b1}})
              issue_cnt <= issue_cnt + 16'd1;
            if (halt) begin
              state <= HALTED;
            end else begin
              imem_req <= 1'b1;
              state    <= FETCH;
            end
          end
        end
        HALTED: ;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus randomized
// traffic against a transaction-level PC / memory reference model.
module tb_fetch_ctrl;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        halt = 1'b0;
  logic [31:0] pc;
  logic        misalign_err;
  logic [15:0] issue_cnt;

  fetch_ctrl #(.RESET_PC(RESET_PC)) dut (
    .clk          (clk),
    .clr          (clr),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .inst_valid   (inst_valid),
    .inst         (inst),
    .inst_pc      (inst_pc),
    .inst_ready   (inst_ready),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .halt         (halt),
    .pc           (pc),
    .misalign_err (misalign_err),
    .issue_cnt    (issue_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // Reference model: what decode should see, in program-order terms.
  logic [31:0] m_pc, m_inst, m_inst_pc;
  logic [15:0] m_cnt;
  bit          m_started, m_valid, m_halted, m_mis;

  // Memory responder: one outstanding read, address latched at request start.
  bit          r_busy, r_useful, force_ack;
  logic [31:0] r_addr;
  int          r_lat, lat_min, lat_max;
  logic [31:0] req_log[$];

  task automatic model_reset();
    m_pc = RESET_PC; m_inst = '0; m_inst_pc = '0; m_cnt = '0;
    m_started = 0; m_valid = 0; m_halted = 0; m_mis = 0;
    r_busy = 0; r_useful = 0; force_ack = 0; r_lat = 0;
  endtask

  task automatic step(input bit rdy, input bit redir, input logic [31:0] rpc, input bit hlt);
    bit          ack;
    logic [31:0] rdata;
    bit          exp_req;
    exp_req = m_started && !m_halted && !m_valid;
    check("imem_req", imem_req, exp_req);
    if (exp_req) check("imem_addr", imem_addr, m_pc);
    check("inst_valid", inst_valid, m_valid);
    if (m_valid) begin
      check("inst", inst, m_inst);
      check("inst_pc", inst_pc, m_inst_pc);
    end
    check("pc", pc, m_pc);
    check("misalign_err", misalign_err, m_mis);
    check("issue_cnt", issue_cnt, m_cnt);

    ack = 0;
    rdata = 32'hDEAD_BEEF;
    if (imem_req && !r_busy) begin
      r_busy = 1; r_useful = 1; r_addr = imem_addr;
      r_lat = $urandom_range(lat_max, lat_min);
      req_log.push_back(imem_addr);
    end
    if (r_busy) begin
      if (r_lat == 0) begin ack = 1; rdata = mem_word(r_addr); end
      else r_lat--;
    end else if (force_ack) begin
      ack = 1; force_ack = 0;
    end

    imem_ack = ack; imem_rdata = rdata;
    inst_ready = rdy; redirect = redir; redirect_pc = rpc; halt = hlt;

    if (!m_halted) begin
      if (redir && rpc[1:0] != 2'b00) m_mis = 1;
      if (!m_started) begin
        m_started = 1;
        if (redir) m_pc = {rpc[31:2], 2'b00};
      end else if (m_valid) begin
        if (redir) begin
          m_pc = {rpc[31:2], 2'b00}; m_valid = 0;
        end else if (rdy) begin
          m_pc = m_pc + 32'd4; m_valid = 0;
          if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
          if (hlt) m_halted = 1;
        end
      end else begin
        if (redir) begin m_pc = {rpc[31:2], 2'b00}; r_useful = 0; end
        if (ack && r_busy && r_useful) begin
          m_valid = 1; m_inst = rdata; m_inst_pc = m_pc;
        end
      end
    end
    if (ack) r_busy = 0;

    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    imem_ack = 0; inst_ready = 0; redirect = 0; halt = 0;
    #2 clr = 1'b1;
    #1;
    check("rst_imem_req", imem_req, 0);
    check("rst_inst_valid", inst_valid, 0);
    check("rst_inst", inst, 0);
    check("rst_inst_pc", inst_pc, 0);
    check("rst_pc", pc, RESET_PC);
    check("rst_misalign", misalign_err, 0);
    check("rst_issue_cnt", issue_cnt, 0);
    model_reset();
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 40 && !inst_valid; i++) step(0, 0, 32'h0, 0);
    check(tag, inst_valid, 1);
  endtask

  initial begin
    bit          rd, rr, hl;
    logic [31:0] rpc;
    model_reset();
    lat_min = 2; lat_max = 2;
    @(negedge clk);
    do_reset();

    // Straight-line fetch with a fixed 2-cycle memory.
    req_log.delete();
    for (int i = 0; i < 60 && issue_cnt != 16'd3; i++) step(1, 0, 32'h0, 0);
    check("seq_issue_cnt", issue_cnt, 3);
    check("seq_n_req", req_log.size() >= 3, 1);
    if (req_log.size() >= 3) begin
      check("seq_addr0", req_log[0], 32'h0);
      check("seq_addr1", req_log[1], 32'h4);
      check("seq_addr2", req_log[2], 32'h8);
    end

    // Decode stall: buffer and pc must hold.
    wait_valid("stall_wait");
    for (int i = 0; i < 5; i++) step(0, 0, 32'h0, 0);
    step(1, 0, 32'h0, 0);

    // Redirect during fetch; in-flight data dropped.
    step(0, 1, 32'h100, 0);
    wait_valid("redir_wait");
    check("redir_inst_pc", inst_pc, 32'h100);
    check("redir_inst", inst, mem_word(32'h100));

    // Misaligned redirect from ISSUE.
    step(0, 1, 32'h203, 0);
    check("mis_flag", misalign_err, 1);
    check("mis_addr", imem_addr, 32'h200);

    // PC wrap at the top of the address space.
    step(0, 1, 32'hFFFF_FFFC, 0);
    wait_valid("wrap_wait");
    check("wrap_inst_pc", inst_pc, 32'hFFFF_FFFC);
    step(1, 0, 32'h0, 0);
    check("wrap_addr", imem_addr, 32'h0);

    // Halt with handshake, then redirect/halt must be ignored.
    wait_valid("halt_wait");
    step(1, 0, 32'h0, 1);
    for (int i = 0; i < 10; i++) begin
      check("halt_req", imem_req, 0);
      step(i[0], 1, 32'h0000_0403, 1);
    end

    // Reset mid-fetch, then a stale ack during IDLE.
    do_reset();
    step(0, 0, 32'h0, 0);
    check("mid_req", imem_req, 1);
    do_reset();
    force_ack = 1;
    wait_valid("restart_wait");
    check("restart_inst_pc", inst_pc, RESET_PC);
    check("restart_inst", inst, mem_word(RESET_PC));

    // Randomized traffic.
    lat_min = 0; lat_max = 3;
    for (int e = 0; e < 5; e++) begin
      do_reset();
      for (int i = 0; i < 400; i++) begin
        rd  = ($urandom_range(3, 0) != 0);
        rr  = ($urandom_range(11, 0) == 0);
        hl  = ($urandom_range(79, 0) == 0);
        rpc = $urandom;
        if ($urandom_range(1, 0) == 1) rpc[1:0] = 2'b00;
        if ($urandom_range(7, 0) == 0) rpc[31:2] = 30'h3FFF_FFFE;
        step(rd, rr, rpc, hl);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the PC value loaded on reset.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 clr  input  1  reset, asynchronous, active-high.
REQ-004 imem_req  output  1  instruction-memory read request.
REQ-005 imem_addr  output  32  word-aligned fetch address.
REQ-006 imem_ack  input  1  one-cycle pulse; imem_rdata is valid in the same cycle.
REQ-007 imem_rdata  input  32  fetched instruction word.
REQ-008 inst_valid  output  1  inst, inst_pc hold a fetched instruction.
REQ-009 inst  output  32  instruction to decode.
REQ-010 inst_pc  output  32  address of inst.
REQ-011 inst_ready  input  1  decode accepts inst this cycle.
REQ-012 redirect  input  1  branch/jump taken; one-cycle pulse.
REQ-013 redirect_pc  input  32  target address for redirect.
REQ-014 halt  input  1  stop fetching after the current instruction.
REQ-015 pc  output  32  current architectural fetch PC.
REQ-016 misalign_err  output  1  sticky; set when a redirect target has nonzero bits [1:0].
REQ-017 issue_cnt  output  16  count of accepted instructions, saturating.

Function
REQ-018 FSM states: IDLE, FETCH, ISSUE, HALTED.
REQ-019 IDLE lasts exactly one cycle after reset, then goes to FETCH.
REQ-020 FETCH: imem_req=1, imem_addr=pc; imem_req held high until imem_ack.
REQ-021 On imem_ack in FETCH with no pending kill: capture imem_rdata into inst, pc into inst_pc, go to ISSUE.
REQ-022 ISSUE: inst_valid=1; inst and inst_pc held stable until inst_valid&inst_ready.
REQ-023 On handshake in ISSUE: pc <= pc+4, modulo 2^32 (32'hFFFF_FFFC wraps to 0), issue_cnt +1, then go to FETCH, or to HALTED if halt=1.
REQ-024 Fetch-to-issue latency: inst_valid rises the cycle after imem_ack.
REQ-025 Redirect in IDLE or ISSUE: pc <= {redirect_pc[31:2],2'b00}; inst_valid drops next cycle; next state FETCH; no pc+4 or issue_cnt increment even if inst_ready=1 in that cycle.
REQ-026 Redirect in FETCH before or with imem_ack: pc updated as in REQ-025; outstanding request is not aborted; kill flag set and that response discarded; a new request for the new pc issues the cycle after the discarded ack (or the same request completes if ack coincides; the data is discarded and a new fetch starts).
REQ-027 Two redirects before the ack: last target wins; only one response discarded.
REQ-028 redirect_pc[1:0]!=0 on redirect sets misalign_err; cleared only by reset.
REQ-029 HALTED: imem_req=0, inst_valid=0, redirect and halt ignored; exit only via clr.
REQ-030 halt outside an ISSUE handshake has no effect.
REQ-031 issue_cnt saturates at 16'hFFFF.

Reset
REQ-032 clr=1 forces immediately: state IDLE, pc=RESET_PC, imem_req=0, inst_valid=0, inst=0, inst_pc=0, kill=0, misalign_err=0, issue_cnt=0.
REQ-033 clr mid-fetch abandons the outstanding request; a late imem_ack after reset release while not in FETCH is ignored.

Structure
REQ-034 State encoding constants and the instruction width constant belong in the shared CPU package.
REQ-035 pc register is a single sub-module: a 32-bit clocked register with asynchronous clr to RESET_PC and a write enable, named pc_reg.

Verification
REQ-036 Reset release, imem_ack after 2 cycles, inst_ready=1 -> imem_addr 0x0, 0x4, 0x8 in sequence; issue_cnt=3 after three handshakes.
REQ-037 inst_ready low for 5 cycles in ISSUE -> inst and inst_pc unchanged, pc unchanged, no new imem_req.
REQ-038 redirect to 0x100 in FETCH, ack 2 cycles later -> data discarded, next imem_addr=0x100, inst_pc=0x100 at issue.
REQ-039 redirect to 0x203 -> misalign_err=1, next imem_addr=0x200.
REQ-040 pc=0xFFFF_FFFC handshake -> next imem_addr=0x0; halt with handshake -> HALTED, imem_req stays 0 for 10 cycles.
REQ-041 clr asserted while imem_req=1 -> all outputs reset same cycle; restart fetches RESET_PC.
